// File: rtl/instr_mem_arbiter_if.sv
// Bundles the fetch port, loader port and instruction RAM wrapper signals of instr_mem_arbiter.
// slave = arbiter side, master = requester/memory side.
interface instr_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  core_req_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic                  core_gnt_o;
  logic                  core_rvalid_o;
  logic [DATA_WIDTH-1:0] core_rdata_o;

  logic                  ld_req_i;
  logic                  ld_we_i;
  logic [ADDR_WIDTH-1:0] ld_addr_i;
  logic [DATA_WIDTH-1:0] ld_wdata_i;
  logic [BE_WIDTH-1:0]   ld_be_i;
  logic                  ld_gnt_o;
  logic                  ld_rvalid_o;
  logic [DATA_WIDTH-1:0] ld_rdata_o;
  logic                  ld_err_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  core_req_i, core_addr_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    input  ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_be_i,
    output ld_gnt_o, ld_rvalid_o, ld_rdata_o, ld_err_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_addr_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    output ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_be_i,
    input  ld_gnt_o, ld_rvalid_o, ld_rdata_o, ld_err_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Fetch/loader arbiter for the instruction RAM: zero-cycle grant, response 1 cycle later; loser holds its request.
// Loader has priority; `INSTR_ARB_STARVE_GUARD_EN bounds fetch starvation to STARVE_LIMIT cycles.
module instr_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  instr_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_CORE,
    RESP_LD,
    RESP_LD_ERR
  } owner_t;

  owner_t owner_q;
  logic   ld_wr_q;
  logic   core_gnt;
  logic   ld_gnt;
  logic   ld_blocked;
  logic   force_core;

`ifdef INSTR_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q;

  assign force_core = bus.core_req_i && (starve_cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (bus.core_req_i && !core_gnt) begin
      if (starve_cnt_q != 4'hF) starve_cnt_q <= starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_q <= '0;
    end
  end
`else
  assign force_core = 1'b0;
`endif

  assign ld_gnt     = bus.ld_req_i && !force_core;
  assign core_gnt   = bus.core_req_i && !ld_gnt;
  // Boot ROM window writes are acknowledged but never reach the memory.
  assign ld_blocked = ld_gnt && bus.ld_we_i && bus.ld_addr_i[ADDR_WIDTH-1];

  assign bus.core_gnt_o = core_gnt;
  assign bus.ld_gnt_o   = ld_gnt;

  always_comb begin
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '0;
    if (core_gnt) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_addr_o = bus.core_addr_i;
      bus.mem_be_o   = '1;
    end else if (ld_gnt && !ld_blocked) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = bus.ld_we_i;
      bus.mem_addr_o  = bus.ld_addr_i;
      bus.mem_wdata_o = bus.ld_wdata_i;
      bus.mem_be_o    = bus.ld_be_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= RESP_NONE;
      ld_wr_q <= 1'b0;
    end else begin
      ld_wr_q <= ld_gnt && bus.ld_we_i;
      if (core_gnt)        owner_q <= RESP_CORE;
      else if (ld_blocked) owner_q <= RESP_LD_ERR;
      else if (ld_gnt)     owner_q <= RESP_LD;
      else                 owner_q <= RESP_NONE;
    end
  end

  assign bus.core_rvalid_o = (owner_q == RESP_CORE);
  assign bus.core_rdata_o  = (owner_q == RESP_CORE) ? bus.mem_rdata_i : '0;
  assign bus.ld_rvalid_o   = (owner_q == RESP_LD) || (owner_q == RESP_LD_ERR);
  assign bus.ld_err_o      = (owner_q == RESP_LD_ERR);
  assign bus.ld_rdata_o    = (owner_q == RESP_LD && !ld_wr_q) ? bus.mem_rdata_i : '0;
endmodule
